// File: rtl/umi_host_pkg.sv
// rtl/umi_host_pkg.sv - UMI opcodes, command field offsets and host FSM states
package umi_host_pkg;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    localparam int OPCODE_LSB = 0;
    localparam int SIZE_LSB   = 5;
    localparam int LEN_LSB    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_OUT     = 3'd5
    } host_state_e;

endpackage

// File: rtl/umi_host_cmd_pack.sv
// rtl/umi_host_cmd_pack.sv - combinational UMI command builder from opcode/size/len
module umi_host_cmd_pack
    import umi_host_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [4:0]    opcode_i,
    input  logic [2:0]    size_i,
    input  logic [7:0]    len_i,
    output logic [CW-1:0] cmd_o
);

    always_comb begin
        cmd_o = '0;
        cmd_o[OPCODE_LSB +: 5] = opcode_i;
        cmd_o[SIZE_LSB   +: 3] = size_i;
        cmd_o[LEN_LSB    +: 8] = len_i;
    end

endmodule

// File: rtl/umi_fir_host.sv
// rtl/umi_fir_host.sv - UMI host that writes each sample to the FIR and reads back the result (optional UMI_HOST_TIMEOUT_EN)
module umi_fir_host #(
    parameter int             DW             = 128,
    parameter int             AW             = 64,
    parameter int             CW             = 32,
    parameter int             SW             = 16,
    parameter logic [AW-1:0]  SAMPLE_ADDR    = '0,
    parameter logic [AW-1:0]  RESULT_ADDR    = AW'(64'h8),
    parameter logic [AW-1:0]  HOST_ADDR      = AW'(64'h1000),
    parameter int             TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [SW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [SW-1:0] out_data,
    input  logic          out_ready,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready,
    output logic          err_resp,
    output logic          err_timeout
);
    import umi_host_pkg::*;

    localparam logic [2:0] SIZE_ENC = 3'($clog2(SW / 8));

    logic [CW-1:0] wr_cmd, rd_cmd;

    umi_host_cmd_pack #(.CW(CW)) u_wr_cmd (
        .opcode_i(REQ_WRITE), .size_i(SIZE_ENC), .len_i(8'd0), .cmd_o(wr_cmd)
    );
    umi_host_cmd_pack #(.CW(CW)) u_rd_cmd (
        .opcode_i(REQ_READ), .size_i(SIZE_ENC), .len_i(8'd0), .cmd_o(rd_cmd)
    );

    host_state_e   state_q, state_d;
    logic [SW-1:0] sample_q, sample_d, result_q, result_d;
    logic          err_resp_q, err_resp_d;
    logic          in_ready_q, out_valid_q, req_valid_q, resp_ready_q;
    logic [CW-1:0] req_cmd_q, req_cmd_d;
    logic [AW-1:0] req_dst_q, req_dst_d, req_src_q, req_src_d;
    logic [DW-1:0] req_data_q, req_data_d;
    logic [4:0]    exp_opcode;
    logic          resp_bad, timeout_hit, in_resp_state, unused_ok;

    assign in_resp_state = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);
    assign exp_opcode    = (state_q == ST_WR_RESP) ? RESP_WRITE : RESP_READ;
    assign resp_bad      = (uhost_resp_cmd[4:0] != exp_opcode) || (uhost_resp_dstaddr != HOST_ADDR);

`ifdef UMI_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_timeout_q;

    assign timeout_hit = in_resp_state && !uhost_resp_valid
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // The count is held at zero outside the response states, so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (!in_resp_state || uhost_resp_valid) wait_cnt_q <= '0;
            else                                    wait_cnt_q <= wait_cnt_q + 1'b1;
            if (timeout_hit) err_timeout_q <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
    assign unused_ok   = ^{uhost_resp_srcaddr, uhost_resp_data[DW-1:SW], uhost_resp_cmd[CW-1:5]};
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_ok   = ^{uhost_resp_srcaddr, uhost_resp_data[DW-1:SW], uhost_resp_cmd[CW-1:5],
                           32'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        result_d   = result_q;
        err_resp_d = err_resp_q;
        case (state_q)
            ST_IDLE:    if (in_valid && in_ready_q) begin
                            sample_d = in_data;
                            state_d  = ST_WR_REQ;
                        end
            ST_WR_REQ:  if (uhost_req_ready) state_d = ST_WR_RESP;
            ST_WR_RESP: if (uhost_resp_valid) begin
                            err_resp_d = err_resp_q | resp_bad;
                            state_d    = ST_RD_REQ;
                        end else if (timeout_hit) begin
                            state_d = ST_IDLE;
                        end
            ST_RD_REQ:  if (uhost_req_ready) state_d = ST_RD_RESP;
            ST_RD_RESP: if (uhost_resp_valid) begin
                            err_resp_d = err_resp_q | resp_bad;
                            result_d   = uhost_resp_data[SW-1:0];
                            state_d    = ST_OUT;
                        end else if (timeout_hit) begin
                            state_d = ST_IDLE;
                        end
            ST_OUT:     if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request fields derive from the next state so they register together with valid.
    always_comb begin
        req_cmd_d  = '0;
        req_dst_d  = '0;
        req_src_d  = '0;
        req_data_d = '0;
        if (state_d == ST_WR_REQ) begin
            req_cmd_d  = wr_cmd;
            req_dst_d  = SAMPLE_ADDR;
            req_src_d  = HOST_ADDR;
            req_data_d = DW'(sample_d);
        end else if (state_d == ST_RD_REQ) begin
            req_cmd_d  = rd_cmd;
            req_dst_d  = RESULT_ADDR;
            req_src_d  = HOST_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            sample_q     <= '0;
            result_q     <= '0;
            err_resp_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            req_cmd_q    <= '0;
            req_dst_q    <= '0;
            req_src_q    <= '0;
            req_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            result_q     <= result_d;
            err_resp_q   <= err_resp_d;
            in_ready_q   <= (state_d == ST_IDLE);
            out_valid_q  <= (state_d == ST_OUT);
            req_valid_q  <= (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
            resp_ready_q <= (state_d == ST_WR_RESP) || (state_d == ST_RD_RESP);
            req_cmd_q    <= req_cmd_d;
            req_dst_q    <= req_dst_d;
            req_src_q    <= req_src_d;
            req_data_q   <= req_data_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = result_q;
    assign uhost_req_valid   = req_valid_q;
    assign uhost_req_cmd     = req_cmd_q;
    assign uhost_req_dstaddr = req_dst_q;
    assign uhost_req_srcaddr = req_src_q;
    assign uhost_req_data    = req_data_q;
    assign uhost_resp_ready  = resp_ready_q;
    assign err_resp          = err_resp_q;

endmodule

// File: tb/tb_umi_fir_host.sv
// tb/tb_umi_fir_host.sv - randomized self-checking bench for umi_fir_host with a behavioural FIR device
module tb_umi_fir_host;
    localparam int DW = 128, AW = 64, CW = 32, SW = 16;

    logic          clk = 1'b0, nreset = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [SW-1:0] out_data;
    logic          uhost_req_valid, uhost_req_ready = 1'b0;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid = 1'b0, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd = '0;
    logic [AW-1:0] uhost_resp_dstaddr = '0, uhost_resp_srcaddr = '0;
    logic [DW-1:0] uhost_resp_data = '0;
    logic          err_resp, err_timeout;

    always #5 clk = ~clk;

    umi_fir_host #(.DW(DW), .AW(AW), .CW(CW), .SW(SW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready),
        .err_resp(err_resp), .err_timeout(err_timeout)
    );

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device: result register returns twice the last written sample.
    typedef struct packed {
        logic          bad;
        logic [CW-1:0] cmd;
        logic [DW-1:0] data;
    } resp_t;
    resp_t         dev_q[$];
    logic [SW-1:0] dev_reg = '0;
    logic [DW-1:0] last_wr_data = '0;
    bit            rand_dev = 0, mute_rd = 0, bad_wr_once = 0;
    int            rd_accepts = 0;

    initial begin
        logic          req_hs, resp_hs, rst, stall, prev_stall;
        logic [CW-1:0] c_cmd, p_cmd;
        logic [AW-1:0] c_dst, c_src, p_dst, p_src;
        logic [DW-1:0] c_data, p_data, d;
        resp_t         r;
        prev_stall = 0;
        p_cmd = '0; p_dst = '0; p_src = '0; p_data = '0;
        forever begin
            @(negedge clk);
            req_hs  = uhost_req_valid & uhost_req_ready;
            resp_hs = uhost_resp_valid & uhost_resp_ready;
            rst     = !nreset;
            c_cmd = uhost_req_cmd; c_dst = uhost_req_dstaddr;
            c_src = uhost_req_srcaddr; c_data = uhost_req_data;
            if (prev_stall)
                chk("req_hold", {uhost_req_valid, c_cmd == p_cmd, c_dst == p_dst,
                                 c_src == p_src, c_data == p_data}, 5'b11111);
            stall = uhost_req_valid & !uhost_req_ready & nreset;
            prev_stall = stall;
            p_cmd = c_cmd; p_dst = c_dst; p_src = c_src; p_data = c_data;
            @(posedge clk);
            #1;
            if (rst) begin
                dev_q.delete();
            end else begin
                if (resp_hs) begin
                    r = dev_q.pop_front();
                    if (r.bad) chk("err_resp_set", err_resp, 1);
                end
                if (req_hs) begin
                    if (c_cmd[4:0] == 5'h03) begin
                        chk("wr_cmd", c_cmd, 32'h23);
                        chk("wr_dst", c_dst, 64'h0);
                        chk("wr_src", c_src, 64'h1000);
                        chk("wr_data_hi", c_data >> SW, 128'h0);
                        dev_reg = c_data[SW-1:0];
                        last_wr_data = c_data;
                        r.bad  = bad_wr_once;
                        r.cmd  = {27'($urandom), bad_wr_once ? 5'h02 : 5'h04};
                        r.data = {$urandom, $urandom, $urandom, $urandom};
                        bad_wr_once = 0;
                        dev_q.push_back(r);
                    end else begin
                        chk("rd_cmd", c_cmd, 32'h21);
                        chk("rd_dst", c_dst, 64'h8);
                        chk("rd_src", c_src, 64'h1000);
                        chk("rd_data", c_data, 128'h0);
                        rd_accepts++;
                        d = {$urandom, $urandom, $urandom, $urandom};
                        d[SW-1:0] = dev_reg * 16'd2;
                        r.bad  = 1'b0;
                        r.cmd  = {27'($urandom), 5'h02};
                        r.data = d;
                        if (!mute_rd) dev_q.push_back(r);
                    end
                end
            end
            uhost_req_ready = rand_dev ? 1'($urandom_range(0, 1)) : 1'b1;
            uhost_resp_valid = (dev_q.size() != 0) && (!rand_dev || ($urandom_range(0, 2) != 0));
            if (uhost_resp_valid) begin
                uhost_resp_cmd     = dev_q[0].cmd;
                uhost_resp_data    = dev_q[0].data;
                uhost_resp_dstaddr = 64'h1000;
                uhost_resp_srcaddr = {$urandom, $urandom};
            end else begin
                uhost_resp_cmd = '0; uhost_resp_data = '0;
                uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0;
            end
        end
    end

    bit rand_sink = 0, sink_force = 1;
    initial forever begin
        @(posedge clk);
        #2 out_ready = rand_sink ? 1'($urandom_range(0, 1)) : sink_force;
    end

    // Output scoreboard: every accepted sample must come back as sample*2, in order.
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] last_out = '0, prev_out = '0;
    int            cyc = 0, in_hs_cyc = 0, out_rise_cyc = 0;
    bit            prev_out_stall = 0, prev_out_valid = 0;
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!nreset) begin
            exp_q.delete();
            prev_out_stall = 0;
            prev_out_valid = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data * 16'd2);
                in_hs_cyc = cyc;
            end
            if (out_valid && !prev_out_valid) out_rise_cyc = cyc;
            if (prev_out_stall) chk("out_hold", {out_valid, out_data}, {1'b1, prev_out});
            if (out_valid) begin
                if (exp_q.size() == 0) chk("out_unexpected", out_valid, 0);
                else if (out_ready) begin
                    last_out = out_data;
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            prev_out_stall = out_valid && !out_ready;
            prev_out = out_data;
            prev_out_valid = out_valid;
        end
    end

    task automatic send(input logic [SW-1:0] v);
        int n = 0;
        in_valid = 1;
        in_data = v;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        chk("send_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        in_data = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {in_ready, out_valid, uhost_req_valid, uhost_resp_ready,
                            err_resp, err_timeout}, 6'b0);
        chk({tag, "_data"}, {out_data, uhost_req_cmd, uhost_req_dstaddr}, '0);
    endtask

    initial begin
        int base, n;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        nreset = 1;
        @(posedge clk);
        #1;

        send(16'h0005);
        drain();
        chk("first_wr_data", last_wr_data, 128'h5);
        chk("first_out", last_out, 16'h000A);
        chk("latency", 32'(out_rise_cyc - in_hs_cyc), 5);

        rand_dev = 1;
        rand_sink = 1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 send(16'($urandom));
        end
        drain();
        rand_dev = 0;
        rand_sink = 0;
        sink_force = 0;
        chk("no_err_random", err_resp, 0);

        send(16'h1234);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_reached", out_valid, 1);
        @(posedge clk);
        #1 in_valid = 1;
        in_data = 16'h4321;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("in_blocked", in_ready, 0);
        end
        @(posedge clk);
        #1 sink_force = 1;
        @(negedge clk);
        chk("out_still_valid", out_valid, 1);
        @(negedge clk);
        chk("accept_after_release", {in_ready, in_valid}, 2'b11);
        @(posedge clk);
        #1 in_valid = 0;
        drain();
        chk("out_after_release", last_out, 16'h8642);

        bad_wr_once = 1;
        send(16'h0101);
        drain();
        chk("err_sticky", err_resp, 1);
        chk("err_result", last_out, 16'h0202);

        mute_rd = 1;
        base = rd_accepts;
        send(16'h0777);
        n = 0;
        while (rd_accepts == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rd_resp_wait", {uhost_resp_ready, out_valid}, 2'b10);
        @(posedge clk);
        #1 nreset = 0;
        @(posedge clk);
        #1 check_all_zero("pulse");
        nreset = 1;
        mute_rd = 0;
        repeat (3) @(posedge clk);
        #1 send(16'h0030);
        drain();
        chk("post_reset_out", last_out, 16'h0060);
        chk("post_reset_err", {err_resp, err_timeout}, 2'b00);

`ifdef UMI_HOST_TIMEOUT_EN
        mute_rd = 1;
        base = rd_accepts;
        send(16'h0055);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_accepts == base && n < 100);
        repeat (15) @(negedge clk);
        chk("timeout_not_yet", err_timeout, 0);
        @(negedge clk);
        chk("timeout_set", {err_timeout, in_ready, out_valid}, 3'b110);
        exp_q.delete();
        mute_rd = 0;
        repeat (8) @(negedge clk);
        chk("timeout_sticky", {err_timeout, out_valid}, 2'b10);
`else
        chk("timeout_tied", err_timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule
